// File: rtl/encoder_8x3.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8x3
// Description : Registered 8-to-3 one-hot encoder. Flags one-hot inputs as
//               valid, multi-hot inputs as errors, and keeps a saturating
//               8-bit count of error captures.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8x3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [7:0] C_CNT_MAX = 8'hFF;

  logic [3:0] w_pop;
  logic [2:0] w_idx;
  logic       w_onehot;
  logic       w_multi;
  logic       w_cnt_inc;

  logic [2:0] r_out;
  logic       r_valid;
  logic       r_err;
  logic [7:0] r_err_count;

  // Population count and OR-combined bit index; the index is only used when
  // exactly one bit is set, so no priority ordering is involved.
  always_comb begin
    w_pop = 4'd0;
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, in[i]};
      if (in[i]) begin
        w_idx = w_idx | 3'(i);
      end
    end
  end

  assign w_onehot  = (w_pop == 4'd1);
  assign w_multi   = (w_pop >  4'd1);
  assign w_cnt_inc = w_multi && (r_err_count != C_CNT_MAX);

  // Capture the encoded result every edge; zero and multi-hot inputs force out to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= 3'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_out   <= w_onehot ? w_idx : 3'd0;
      r_valid <= w_onehot;
      r_err   <= w_multi;
    end
  end

  // Saturating error counter, advanced on the same edge that captures err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_cnt_inc) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign out       = r_out;
  assign valid     = r_valid;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_encoder_8x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_8x3
// Description : Self-checking bench for encoder_8x3 with a behavioural model
//               and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_8x3;

  logic       clk;
  logic       rst;
  logic [7:0] tb_in;
  logic [2:0] tb_out;
  logic       tb_valid;
  logic       tb_err;
  logic [7:0] tb_err_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [2:0] exp_out;
  logic       exp_valid;
  logic       exp_err;
  int         exp_cnt;

  encoder_8x3 dut (
    .clk       (clk),
    .rst       (rst),
    .in        (tb_in),
    .out       (tb_out),
    .valid     (tb_valid),
    .err       (tb_err),
    .err_count (tb_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what the outputs should be after the next edge samples v.
  task automatic model_capture(input logic [7:0] v);
    int ones;
    ones = $countones(v);
    exp_out   = 3'd0;
    exp_valid = (ones == 1);
    exp_err   = (ones >= 2);
    if (ones == 1) begin
      for (int k = 0; k < 8; k++) begin
        if (v == (8'd1 << k)) exp_out = 3'(k);
      end
    end
    if (exp_err && exp_cnt < 255) exp_cnt = exp_cnt + 1;
  endtask

  task automatic model_reset();
    exp_out = 3'd0; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = 0;
  endtask

  // Drive v, let one rising edge sample it, land 1 time unit after the edge.
  task automatic step(input logic [7:0] v);
    tb_in = v;
    @(posedge clk);
    model_capture(v);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tb_in = 8'hFF;
    model_reset();
    #1;
    n_checks++;
    if ({tb_out, tb_valid, tb_err, tb_err_count} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_initial: got out=%b valid=%b err=%b cnt=%0d, want all 0",
               tb_out, tb_valid, tb_err, tb_err_count);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({tb_out, tb_valid, tb_err, tb_err_count} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_held: got out=%b valid=%b err=%b cnt=%0d, want all 0",
               tb_out, tb_valid, tb_err, tb_err_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_walking();
    for (int i = 0; i < 8; i++) begin
      step(8'd1 << i);
      n_checks++;
      if (tb_out !== 3'(i) || tb_valid !== 1'b1 || tb_err !== 1'b0 || tb_err_count !== 8'd0) begin
        n_errors++;
        $display("FAIL walking[%0d]: got out=%b valid=%b err=%b cnt=%0d, want out=%b valid=1 err=0 cnt=0",
                 i, tb_out, tb_valid, tb_err, tb_err_count, 3'(i));
      end
    end
  endtask

  task automatic test_multihot();
    step(8'b0000_0110);
    n_checks++;
    if (tb_out !== 3'd0 || tb_valid !== 1'b0 || tb_err !== 1'b1 || tb_err_count !== 8'd1) begin
      n_errors++;
      $display("FAIL multihot: got out=%b valid=%b err=%b cnt=%0d, want out=000 valid=0 err=1 cnt=1",
               tb_out, tb_valid, tb_err, tb_err_count);
    end
  endtask

  task automatic test_zero();
    step(8'd0);
    n_checks++;
    if (tb_out !== 3'd0 || tb_valid !== 1'b0 || tb_err !== 1'b0 || tb_err_count !== 8'd1) begin
      n_errors++;
      $display("FAIL zero: got out=%b valid=%b err=%b cnt=%0d, want out=000 valid=0 err=0 cnt=1",
               tb_out, tb_valid, tb_err, tb_err_count);
    end
  endtask

  task automatic test_stability();
    logic [2:0] o0;
    logic       v0, e0;
    step(8'b0001_0000);
    o0 = tb_out; v0 = tb_valid; e0 = tb_err;
    n_checks++;
    if (o0 !== 3'd4 || v0 !== 1'b1 || e0 !== 1'b0) begin
      n_errors++;
      $display("FAIL stability_base: got out=%b valid=%b err=%b, want out=100 valid=1 err=0",
               o0, v0, e0);
    end
    // Wiggle the input while clk sits between edges.
    tb_in = 8'hFF; #1;
    tb_in = 8'h00; #1;
    tb_in = 8'h80; #1;
    n_checks++;
    if (tb_out !== 3'd4 || tb_valid !== 1'b1 || tb_err !== 1'b0) begin
      n_errors++;
      $display("FAIL stability_hold: got out=%b valid=%b err=%b, want out=100 valid=1 err=0",
               tb_out, tb_valid, tb_err);
    end
  endtask

  task automatic test_async_reset();
    // Start clean, build up err_count = 5, then land out = 101.
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    repeat (5) step(8'b1100_0000);
    step(8'b0010_0000);
    n_checks++;
    if (tb_out !== 3'd5 || tb_valid !== 1'b1 || tb_err_count !== 8'd5) begin
      n_errors++;
      $display("FAIL async_pre: got out=%b valid=%b cnt=%0d, want out=101 valid=1 cnt=5",
               tb_out, tb_valid, tb_err_count);
    end
    // Pulse reset between edges; outputs must clear with no clock edge.
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tb_out, tb_valid, tb_err, tb_err_count} !== 13'd0) begin
      n_errors++;
      $display("FAIL async_clear: got out=%b valid=%b err=%b cnt=%0d, want all 0",
               tb_out, tb_valid, tb_err, tb_err_count);
    end
    #2 rst = 1'b0;
    model_reset();
    // First edge after release captures normally; the count stays cleared.
    step(8'b0000_1000);
    n_checks++;
    if (tb_out !== 3'd3 || tb_valid !== 1'b1 || tb_err !== 1'b0 || tb_err_count !== 8'd0) begin
      n_errors++;
      $display("FAIL async_resume: got out=%b valid=%b err=%b cnt=%0d, want out=011 valid=1 err=0 cnt=0",
               tb_out, tb_valid, tb_err, tb_err_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'd1 << $urandom_range(0, 7);
        1:       v = 8'd0;
        default: v = 8'($urandom);
      endcase
      step(v);
      n_checks++;
      if (tb_out !== exp_out || tb_valid !== exp_valid || tb_err !== exp_err ||
          tb_err_count !== 8'(exp_cnt) || (tb_valid & tb_err) !== 1'b0) begin
        n_errors++;
        $display("FAIL random[%0d] in=%b: got out=%b valid=%b err=%b cnt=%0d, want out=%b valid=%b err=%b cnt=%0d",
                 n, v, tb_out, tb_valid, tb_err, tb_err_count, exp_out, exp_valid, exp_err, exp_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      step(8'hFF);
      n_checks++;
      if (tb_err !== 1'b1 || tb_valid !== 1'b0 || tb_out !== 3'd0 || tb_err_count !== 8'(exp_cnt)) begin
        n_errors++;
        $display("FAIL saturation[%0d]: got out=%b valid=%b err=%b cnt=%0d, want out=000 valid=0 err=1 cnt=%0d",
                 n, tb_out, tb_valid, tb_err, tb_err_count, exp_cnt);
      end
    end
    n_checks++;
    if (tb_err_count !== 8'd255) begin
      n_errors++;
      $display("FAIL saturation_final: got cnt=%0d, want 255", tb_err_count);
    end
  endtask

  initial begin
    test_reset();
    test_walking();
    test_multihot();
    test_zero();
    test_stability();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder_8x3.md
ENCODER_8X3 -- requirements
Module: encoder_8x3

Interface
REQ-001 Parameters: none; all widths are fixed as stated below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in  input  8  one-hot request vector; bit i high means code i.
REQ-005 out  output  3  registered binary index of the single high bit of in.
REQ-006 valid  output  1  registered; high when the sampled in was exactly one-hot.
REQ-007 err  output  1  registered; high when the sampled in had two or more bits set.
REQ-008 err_count  output  8  saturating count of clock edges on which err was captured high.

Function
REQ-009 The block SHALL sample in on every rising edge of clk and update out, valid and err from that sample, giving 1-cycle latency and no combinational path from in to any output.
REQ-010 For a one-hot in, out SHALL equal the index of the set bit:
- 00000001->000, 00000010->001, 00000100->010, 00001000->011
- 00010000->100, 00100000->101, 01000000->110, 10000000->111
REQ-011 For a one-hot in, valid SHALL be 1 and err SHALL be 0.
REQ-012 If in is 00000000, then on the next edge out SHALL be 000, valid SHALL be 0 and err SHALL be 0.
REQ-013 If in has two or more bits set, then on the next edge out SHALL be 000, valid SHALL be 0 and err SHALL be 1; no X is ever driven.
REQ-014 valid and err SHALL never both be 1.
REQ-015 The one-hot check SHALL use a bit-population test (count == 1), not a priority scheme.
REQ-016 err_count SHALL increment by 1 on each edge where err is captured as 1.
REQ-017 err_count SHALL saturate at 255 and hold there.
REQ-018 err_count SHALL update on the same edge as err, i.e. it reflects errors up to and including the current err value.
REQ-019 Outputs SHALL hold their value between edges regardless of changes on in.

Reset
REQ-020 While rst is 1, out SHALL be 000, valid 0, err 0 and err_count 0, asynchronously, without waiting for clk.
REQ-021 On the first rising clk edge after rst deasserts, the block SHALL capture in normally.
REQ-022 A reset asserted mid-operation SHALL clear err_count and discard any in value sampled before the reset.

Verification
REQ-023 Walking one-hot: drive in through 00000001 to 10000000, one value per clock -> one cycle later out is 000..111 in order, valid=1, err=0, err_count=0.
REQ-024 Multi-hot: drive in=00000110 for 1 cycle -> next cycle out=000, valid=0, err=1, err_count=1.
REQ-025 Zero input: drive in=00000000 -> next cycle out=000, valid=0, err=0, err_count unchanged.
REQ-026 Saturation: drive in=11111111 for 300 cycles -> err_count reaches 255 and stays 255, err=1 throughout.
REQ-027 Async reset: with err_count=5 and out=101, pulse rst between clock edges -> all outputs are 0 immediately, before the next edge.
REQ-028 Stability: toggle in between edges with no clock edge -> out, valid and err remain unchanged.
